// File: rtl/multicycle_control_if.sv
// Memory handshake between the multi-cycle controller and the shared instruction/data memory.
interface multicycle_control_if;
  logic MemRead;
  logic MemWrite;
  logic IorD;
  logic MemReady;

  modport master (output MemRead, output MemWrite, output IorD, input MemReady);
  modport slave  (input MemRead, input MemWrite, input IorD, output MemReady);
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller (lw/sw/R-format/beq) with memory wait timeout and fault halt.
// Optional retired-instruction counter enabled by defining MC_RETIRE_CNT_EN.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  multicycle_control_if.master mem,
  output logic                 PCEn,
  output logic                 IRWrite,
  output logic                 MemToReg,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 PCSrc,
  output logic [3:0]           ALUcontrol,
  output logic [3:0]           State,
  output logic                 Halted,
  output logic [31:0]          Retired
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    HALT   = 4'd15
  } state_e;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d, wait_inc;
  logic                 mem_wait;
  logic                 funct_ok_c;
  logic [3:0]           alu_r_c;
  logic                 mem_read_c, mem_write_c, iord_c;

  // R-format function decode, shared by next-state and output logic
  always_comb begin
    funct_ok_c = 1'b1;
    alu_r_c    = 4'b0010;
    case (Funct)
      6'b100000: alu_r_c = 4'b0010;
      6'b100010: alu_r_c = 4'b0110;
      6'b100100: alu_r_c = 4'b0000;
      6'b100101: alu_r_c = 4'b0001;
      6'b101010: alu_r_c = 4'b0111;
      default:   funct_ok_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // The wait counter only survives a cycle spent stalling in a memory state,
  // so any state change (including entry to a memory state) clears it.
  always_comb begin
    state_d  = state_q;
    mem_wait = 1'b0;
    wait_inc = wait_q + TIMEOUT_W'(1);
    case (state_q)
      FETCH:  if (mem.MemReady) state_d = DECODE; else mem_wait = 1'b1;
      DECODE: begin
        if (Opcode == OP_LW || Opcode == OP_SW) state_d = MEMADR;
        else if (Opcode == OP_R)                state_d = EXEC;
        else if (Opcode == OP_BEQ)              state_d = BRANCH;
        else                                    state_d = HALT;
      end
      MEMADR: state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem.MemReady) state_d = MEMWB; else mem_wait = 1'b1;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem.MemReady) state_d = FETCH; else mem_wait = 1'b1;
      EXEC:   state_d = funct_ok_c ? ALUWB : HALT;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = HALT;
    endcase
    wait_d = '0;
    if (mem_wait) begin
      wait_d = wait_inc;
      if (MEM_TIMEOUT != 0 && wait_inc == TIMEOUT_W'(MEM_TIMEOUT)) state_d = HALT;
    end
  end

  // Moore decode of datapath controls; write strobes are masked during reset
  always_comb begin
    PCEn        = 1'b0;
    iord_c      = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 1'b0;
    ALUcontrol  = 4'b0000;
    Halted      = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read_c = 1'b1;
        ALUSrcB    = 2'b01;
        ALUcontrol = 4'b0010;
        IRWrite    = mem.MemReady;
        PCEn       = mem.MemReady;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        ALUcontrol = 4'b0010;
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUcontrol = 4'b0010;
      end
      MEMRD: begin
        iord_c     = 1'b1;
        mem_read_c = 1'b1;
      end
      MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
      end
      EXEC: begin
        ALUSrcA    = 1'b1;
        ALUcontrol = alu_r_c;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUcontrol = 4'b0110;
        PCSrc      = 1'b1;
        PCEn       = Zero;
      end
      HALT:    Halted = 1'b1;
      default: Halted = 1'b1;
    endcase
    if (!rst_n) begin
      PCEn        = 1'b0;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  assign mem.MemRead  = mem_read_c;
  assign mem.MemWrite = mem_write_c;
  assign mem.IorD     = iord_c;
  assign State        = state_q;

`ifdef MC_RETIRE_CNT_EN
  logic        retire_c;
  logic [31:0] retired_q;

  assign retire_c = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BRANCH) ||
                    (state_q == MEMWR && mem.MemReady);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        retired_q <= '0;
    else if (retire_c) retired_q <= retired_q + 32'd1;
  end

  assign Retired = retired_q;
`else
  assign Retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors, negedge monitor.
module tb_multicycle_control;

  logic        clk, rst_n;
  logic [5:0]  Opcode, Funct;
  logic        Zero;
  logic        PCEn, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, PCSrc, Halted;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUcontrol, State;
  logic [31:0] Retired;

  multicycle_control_if mif();

  multicycle_control #(.MEM_TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .mem(mif),
    .PCEn(PCEn), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUcontrol(ALUcontrol), .State(State), .Halted(Halted), .Retired(Retired)
  );

  // {PCEn,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,PCSrc,ALUcontrol,Halted}
  function automatic logic [16:0] cw(input logic pcen, input logic iord, input logic mr,
                                     input logic mw, input logic irw, input logic m2r,
                                     input logic rd, input logic rw, input logic sa,
                                     input logic [1:0] sb, input logic pcs,
                                     input logic [3:0] alu, input logic h);
    return {pcen, iord, mr, mw, irw, m2r, rd, rw, sa, sb, pcs, alu, h};
  endfunction

  localparam logic [16:0] C_RST      = cw(0,0,0,0,0,0,0,0,0,2'b01,0,4'b0010,0);
  localparam logic [16:0] C_FETCH_R  = cw(1,0,1,0,1,0,0,0,0,2'b01,0,4'b0010,0);
  localparam logic [16:0] C_FETCH_W  = cw(0,0,1,0,0,0,0,0,0,2'b01,0,4'b0010,0);
  localparam logic [16:0] C_DECODE   = cw(0,0,0,0,0,0,0,0,0,2'b11,0,4'b0010,0);
  localparam logic [16:0] C_MEMADR   = cw(0,0,0,0,0,0,0,0,1,2'b10,0,4'b0010,0);
  localparam logic [16:0] C_MEMRD    = cw(0,1,1,0,0,0,0,0,0,2'b00,0,4'b0000,0);
  localparam logic [16:0] C_MEMWB    = cw(0,0,0,0,0,1,0,1,0,2'b00,0,4'b0000,0);
  localparam logic [16:0] C_MEMWR    = cw(0,1,0,1,0,0,0,0,0,2'b00,0,4'b0000,0);
  localparam logic [16:0] C_EXEC_SLT = cw(0,0,0,0,0,0,0,0,1,2'b00,0,4'b0111,0);
  localparam logic [16:0] C_EXEC_ADD = cw(0,0,0,0,0,0,0,0,1,2'b00,0,4'b0010,0);
  localparam logic [16:0] C_EXEC_OR  = cw(0,0,0,0,0,0,0,0,1,2'b00,0,4'b0001,0);
  localparam logic [16:0] C_EXEC_BAD = cw(0,0,0,0,0,0,0,0,1,2'b00,0,4'b0010,0);
  localparam logic [16:0] C_ALUWB    = cw(0,0,0,0,0,0,1,1,0,2'b00,0,4'b0000,0);
  localparam logic [16:0] C_BR_T     = cw(1,0,0,0,0,0,0,0,1,2'b00,1,4'b0110,0);
  localparam logic [16:0] C_BR_NT    = cw(0,0,0,0,0,0,0,0,1,2'b00,1,4'b0110,0);
  localparam logic [16:0] C_HALT     = cw(0,0,0,0,0,0,0,0,0,2'b00,0,4'b0000,1);

  typedef struct packed {
    logic [15:0] id;
    logic [3:0]  st;
    logic [16:0] cw;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          step_id = 0;
  logic [31:0] ret_exp = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  // Monitor: every cycle the DUT presents a control word; check against the oldest expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [16:0] got;
      e   = sb.pop_front();
      got = {PCEn, mif.IorD, mif.MemRead, mif.MemWrite, IRWrite, MemToReg, RegDst, RegWrite,
             ALUSrcA, ALUSrcB, PCSrc, ALUcontrol, Halted};
      n_cmp++;
      if (State !== e.st) begin
        n_bad++;
        $display("FAIL state step%0d: got %0d want %0d", e.id, State, e.st);
      end
      n_cmp++;
      if (got !== e.cw) begin
        n_bad++;
        $display("FAIL ctrl step%0d: got %b want %b", e.id, got, e.cw);
      end
      n_cmp++;
      if (Retired !== e.ret) begin
        n_bad++;
        $display("FAIL retired step%0d: got %0d want %0d", e.id, Retired, e.ret);
      end
    end
  end

  // One cycle: drive inputs, queue expected outputs for this cycle, advance the clock
  task automatic step(input logic rst, input logic rdy, input logic z,
                      input logic [3:0] st, input logic [16:0] c, input logic rt);
    exp_t e;
    rst_n        = rst;
    mif.MemReady = rdy;
    Zero         = z;
    if (!rst) ret_exp = 0;
    e.id  = 16'(step_id);
    e.st  = st;
    e.cw  = c;
    e.ret = ret_exp;
    sb.push_back(e);
    step_id++;
    @(posedge clk);
    #1;
`ifdef MC_RETIRE_CNT_EN
    if (rt && rst) ret_exp = ret_exp + 32'd1;
`else
    if (rt && !rst) ret_exp = 0;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    mif.MemReady = 1'b0;
    Zero = 1'b0;
    Opcode = 6'b000000;
    Funct = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    step(0, 1, 0, 4'd0, C_RST, 0);

    // lw, memory always ready
    Opcode = 6'b100011;
    step(1, 1, 0, 4'd0, C_FETCH_R, 0);
    step(1, 1, 0, 4'd1, C_DECODE, 0);
    step(1, 1, 0, 4'd2, C_MEMADR, 0);
    step(1, 1, 0, 4'd3, C_MEMRD, 0);
    step(1, 1, 0, 4'd4, C_MEMWB, 1);

    // sw with three stall cycles in MEMWR
    Opcode = 6'b101011;
    step(1, 1, 0, 4'd0, C_FETCH_R, 0);
    step(1, 0, 0, 4'd1, C_DECODE, 0);
    step(1, 0, 0, 4'd2, C_MEMADR, 0);
    step(1, 0, 0, 4'd5, C_MEMWR, 0);
    step(1, 0, 0, 4'd5, C_MEMWR, 0);
    step(1, 0, 0, 4'd5, C_MEMWR, 0);
    step(1, 1, 0, 4'd5, C_MEMWR, 1);

    // R-format slt
    Opcode = 6'b000000; Funct = 6'b101010;
    step(1, 1, 0, 4'd0, C_FETCH_R, 0);
    step(1, 1, 0, 4'd1, C_DECODE, 0);
    step(1, 1, 0, 4'd6, C_EXEC_SLT, 0);
    step(1, 1, 0, 4'd7, C_ALUWB, 1);

    // beq taken then not taken
    Opcode = 6'b000100;
    step(1, 1, 1, 4'd0, C_FETCH_R, 0);
    step(1, 0, 1, 4'd1, C_DECODE, 0);
    step(1, 0, 1, 4'd8, C_BR_T, 1);
    step(1, 1, 0, 4'd0, C_FETCH_R, 0);
    step(1, 0, 0, 4'd1, C_DECODE, 0);
    step(1, 0, 0, 4'd8, C_BR_NT, 1);

    // fetch stalls three cycles, ready on the 4th just beats the timeout; then add
    Opcode = 6'b000000; Funct = 6'b100000;
    step(1, 0, 0, 4'd0, C_FETCH_W, 0);
    step(1, 0, 0, 4'd0, C_FETCH_W, 0);
    step(1, 0, 0, 4'd0, C_FETCH_W, 0);
    step(1, 1, 0, 4'd0, C_FETCH_R, 0);
    step(1, 0, 0, 4'd1, C_DECODE, 0);
    step(1, 0, 0, 4'd6, C_EXEC_ADD, 0);
    step(1, 0, 0, 4'd7, C_ALUWB, 1);

    // or, then illegal funct halts with no register write
    Funct = 6'b100101;
    step(1, 1, 0, 4'd0, C_FETCH_R, 0);
    step(1, 1, 0, 4'd1, C_DECODE, 0);
    step(1, 1, 0, 4'd6, C_EXEC_OR, 0);
    step(1, 1, 0, 4'd7, C_ALUWB, 1);
    Funct = 6'b000111;
    step(1, 1, 0, 4'd0, C_FETCH_R, 0);
    step(1, 1, 0, 4'd1, C_DECODE, 0);
    step(1, 1, 0, 4'd6, C_EXEC_BAD, 0);
    step(1, 1, 0, 4'd15, C_HALT, 0);
    step(1, 1, 1, 4'd15, C_HALT, 0);
    step(0, 1, 0, 4'd0, C_RST, 0);

    // fetch timeout: four stalled cycles lead to HALT
    step(1, 0, 0, 4'd0, C_FETCH_W, 0);
    step(1, 0, 0, 4'd0, C_FETCH_W, 0);
    step(1, 0, 0, 4'd0, C_FETCH_W, 0);
    step(1, 0, 0, 4'd0, C_FETCH_W, 0);
    step(1, 0, 0, 4'd15, C_HALT, 0);
    step(1, 1, 0, 4'd15, C_HALT, 0);
    step(0, 0, 0, 4'd0, C_RST, 0);

    // illegal opcode halts from DECODE
    Opcode = 6'b111111;
    step(1, 1, 0, 4'd0, C_FETCH_R, 0);
    step(1, 1, 0, 4'd1, C_DECODE, 0);
    step(1, 1, 0, 4'd15, C_HALT, 0);
    step(0, 1, 0, 4'd0, C_RST, 0);

    // three retirements, then reset asserted while MEMRD is stalled
    Opcode = 6'b000000; Funct = 6'b100010;
    step(1, 1, 0, 4'd0, C_FETCH_R, 0);
    step(1, 1, 0, 4'd1, C_DECODE, 0);
    step(1, 1, 0, 4'd6, cw(0,0,0,0,0,0,0,0,1,2'b00,0,4'b0110,0), 0);
    step(1, 1, 0, 4'd7, C_ALUWB, 1);
    Funct = 6'b100100;
    step(1, 1, 0, 4'd0, C_FETCH_R, 0);
    step(1, 1, 0, 4'd1, C_DECODE, 0);
    step(1, 1, 0, 4'd6, cw(0,0,0,0,0,0,0,0,1,2'b00,0,4'b0000,0), 0);
    step(1, 1, 0, 4'd7, C_ALUWB, 1);
    Opcode = 6'b000100;
    step(1, 1, 0, 4'd0, C_FETCH_R, 0);
    step(1, 1, 0, 4'd1, C_DECODE, 0);
    step(1, 1, 0, 4'd8, C_BR_NT, 1);
    Opcode = 6'b100011;
    step(1, 1, 0, 4'd0, C_FETCH_R, 0);
    step(1, 0, 0, 4'd1, C_DECODE, 0);
    step(1, 0, 0, 4'd2, C_MEMADR, 0);
    step(1, 0, 0, 4'd3, C_MEMRD, 0);
    step(1, 0, 0, 4'd3, C_MEMRD, 0);
    step(0, 0, 0, 4'd0, C_RST, 0);
    step(1, 0, 0, 4'd0, C_FETCH_W, 0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- FSM controller that sequences the multi-cycle MIPS datapath (shared memory, IR, ALU, register file) over FETCH/DECODE/EXECUTE/MEM/WB steps.
- Supports lw, sw, R-format (add/sub/and/or/slt) and beq.
- Handshakes with the shared instruction/data memory through MemReady, with an optional timeout.
- Decodes the ALU function locally; flags illegal instructions and memory faults by halting.

Parameters:
- MEM_TIMEOUT, 0, max cycles to wait for MemReady in a memory state; 0 = wait forever.
- TIMEOUT_W, 8, width of the wait counter; MEM_TIMEOUT must be < 2**TIMEOUT_W.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- Opcode  input  6  IR[31:26], valid from DECODE onward.
- Funct  input  6  IR[5:0].
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory completes the current access this cycle.
- PCEn  output  1  PC load enable.
- IorD  output  1  0 = address from PC, 1 = address from ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  IR load enable.
- MemToReg  output  1  0 = ALUOut, 1 = MDR to register file.
- RegDst  output  1  0 = rt, 1 = rd.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  0 = PC, 1 = register A.
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- PCSrc  output  1  0 = ALU result, 1 = ALUOut (branch target).
- ALUcontrol  output  4  ALU operation.
- State  output  4  current FSM state, for debug.
- Halted  output  1  sticky fault indicator.
- Retired  output  32  retired instruction count (optional feature).

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, HALT=15.
- Reset (rst_n low, asynchronous): State=FETCH, wait counter=0, Halted=0, Retired=0.
  - While rst_n is low, PCEn, MemRead, MemWrite, IRWrite and RegWrite are forced 0.
- Outputs are decoded combinationally from State; PCEn and IRWrite also depend on MemReady and Zero. Any signal not listed for a state is 0.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUcontrol=0010.
  - If MemReady=1: IRWrite=1, PCEn=1, PCSrc=0, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUcontrol=0010 (branch target to ALUOut). Next state by Opcode:
  - 100011 or 101011 → MEMADR.
  - 000000 → EXEC.
  - 000100 → BRANCH.
  - any other opcode → HALT.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUcontrol=0010. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, MemRead=1. Leaves for MEMWB when MemReady=1.
- MEMWB: RegDst=0, MemToReg=1, RegWrite=1; next state FETCH; retires.
- MEMWR: IorD=1, MemWrite=1. Leaves for FETCH when MemReady=1; retires.
- EXEC: ALUSrcA=1, ALUSrcB=00. ALUcontrol from Funct:
  - 100000 → 0010.
  - 100010 → 0110.
  - 100100 → 0000.
  - 100101 → 0001.
  - 101010 → 0111.
  - other Funct → next state HALT, ALUcontrol=0010, no RegWrite.
  - Legal Funct → next state ALUWB.
- ALUWB: RegDst=1, MemToReg=0, RegWrite=1; next state FETCH; retires.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUcontrol=0110, PCSrc=1, PCEn=Zero. Next state FETCH; retires whether or not the branch is taken.
- HALT: Halted=1, all strobes 0. Remains in HALT until reset.
- Wait counter:
  - Clears on entry to each memory state (FETCH, MEMRD, MEMWR).
  - Increments each cycle spent in a memory state with MemReady=0.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with MemReady still 0, next state is HALT.
  - MemReady=1 in the same cycle always wins over timeout.
- MemReady outside FETCH, MEMRD and MEMWR is ignored.
- Reset asserted mid-access: the request drops immediately and the FSM restarts at FETCH.

Optional Feature:
- Macro: MC_RETIRE_CNT_EN.
- Defined: Retired is a 32-bit counter that increments by 1 on each retiring transition (MEMWB→FETCH, MEMWR→FETCH, ALUWB→FETCH, BRANCH→FETCH). It wraps 0xFFFFFFFF→0 and is cleared by reset.
- Not defined: Retired is tied to 0 and no counter logic is built.

Test Plan:
- lw (Opcode 100011), MemReady held 1 → states 0,1,2,3,4,0 over 5 cycles; RegWrite=1 and MemToReg=1 only in MEMWB; PCEn=1 only in FETCH.
- sw with MemReady low for 3 cycles in MEMWR → MemWrite stays 1 for 4 cycles; returns to FETCH; RegWrite never 1.
- R-format, Funct 101010 → ALUcontrol=0111 in EXEC; ALUWB has RegDst=1, RegWrite=1; Funct 000111 → HALT, Halted=1, RegWrite never 1.
- beq (000100), Zero=1 → PCEn=1 and PCSrc=1 in BRANCH; Zero=0 → PCEn=0; next state FETCH in both cases.
- MEM_TIMEOUT=4, MemReady stuck 0 in FETCH → HALT after 4 waiting cycles; MemReady=1 on the 4th cycle → DECODE instead.
- rst_n pulled low mid-MEMRD → State=0 and MemRead=0 immediately; with MC_RETIRE_CNT_EN, 3 retired instructions give Retired=3 and reset returns it to 0.
